// File: rtl/letc_core_decode_stage.sv
// letc_core_decode_stage: instruction field split, immediate extraction and legality check, with a skid-buffered output
module letc_core_decode_stage #(
  parameter bit SUPPORT_AMO = 1'b1,
  parameter bit SKID_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [29:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [4:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [2:0]  o_funct3,
  output logic [6:0]  o_funct7,
  output logic [31:0] o_imm,
  output logic        o_illegal
);
  localparam logic [4:0] OP_LOAD = 5'b00000, OP_MISC_MEM = 5'b00011, OP_OP_IMM = 5'b00100,
                         OP_AUIPC = 5'b00101, OP_STORE = 5'b01000, OP_AMO = 5'b01011,
                         OP_OP = 5'b01100, OP_LUI = 5'b01101, OP_BRANCH = 5'b11000,
                         OP_JALR = 5'b11001, OP_JAL = 5'b11011, OP_SYSTEM = 5'b11100;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;
  logic [31:2] ins;
  logic [4:0] op;
  logic [2:0] f3;
  logic is_load, is_store, is_branch, is_jalr, is_jal, is_i, is_u, opc_ok;
  logic in_fire, skid_valid;
  dec_t dec, out_q, skid_q;
  assign ins = i_instr;
  assign op = ins[6:2];
  assign f3 = ins[14:12];
  assign is_load = op == OP_LOAD;
  assign is_store = op == OP_STORE;
  assign is_branch = op == OP_BRANCH;
  assign is_jalr = op == OP_JALR;
  assign is_jal = op == OP_JAL;
  assign is_i = is_load | is_jalr | op == OP_OP_IMM | op == OP_MISC_MEM | op == OP_SYSTEM;
  assign is_u = op == OP_LUI | op == OP_AUIPC;
  assign opc_ok = is_i | is_u | is_store | is_branch | is_jal | op == OP_OP | (SUPPORT_AMO && op == OP_AMO);
  always_comb begin
    dec.pc = i_pc;
    dec.opcode = op;
    dec.rd = ins[11:7];
    dec.rs1 = ins[19:15];
    dec.rs2 = ins[24:20];
    dec.funct3 = f3;
    dec.funct7 = ins[31:25];
    dec.imm = is_i      ? {{20{ins[31]}}, ins[31:20]} :
              is_store  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
              is_branch ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
              is_u      ? {ins[31:12], 12'b0} :
              is_jal    ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : 32'b0;
    dec.illegal = !opc_ok | (is_jalr & f3 != 3'b000) | (is_branch & f3[2:1] == 2'b01) |
                  (is_load & (f3 == 3'b011 | f3[2:1] == 2'b11)) | (is_store & f3 >= 3'b011);
  end
  assign o_ready = SKID_EN ? !skid_valid : (!o_valid | i_ready);
  assign in_fire = i_valid & o_ready;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!o_valid || i_ready) begin
      if (skid_valid) begin
        out_q <= skid_q;
        o_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        o_valid <= in_fire;
        if (in_fire) out_q <= dec;
      end
    end else if (in_fire && SKID_EN) begin
      skid_q <= dec;
      skid_valid <= 1'b1;
    end
  end
  assign o_pc = out_q.pc;
  assign o_opcode = out_q.opcode;
  assign o_rd = out_q.rd;
  assign o_rs1 = out_q.rs1;
  assign o_rs2 = out_q.rs2;
  assign o_funct3 = out_q.funct3;
  assign o_funct7 = out_q.funct7;
  assign o_imm = out_q.imm;
  assign o_illegal = out_q.illegal;
endmodule
